// File: rtl/sensor_sched_pkg.sv
// Shared definitions for the sensor scheduler: FSM encoding, command
// opcodes, result tags and the layout of the emitted result word.
package sensor_sched_pkg;

    // WAIT_TICK is part of the encoding, but IDLE evaluates the period tick
    // itself, so the scheduler never enters this state.
    typedef enum logic [3:0] {
        IDLE,
        CMD_RD,
        CMD_DEC,
        WAIT_TICK,
        REQ,
        WAIT_HI,
        WAIT_LO,
        SND,
        NEXT
    } state_t;

    // Command opcodes, carried in cmd_data[31:28]
    localparam logic [3:0] OP_MASK    = 4'h1;
    localparam logic [3:0] OP_PERIOD  = 4'h2;
    localparam logic [3:0] OP_ONESHOT = 4'h3;

    // Result tags
    localparam logic [1:0] TAG_MEAS    = 2'b01;
    localparam logic [1:0] TAG_ONESHOT = 2'b10;
    localparam logic [1:0] TAG_TMO     = 2'b11;

    // Result word layout: {tag, ch, seq, value}
    localparam int TAG_LSB = 30;
    localparam int CH_LSB  = 28;
    localparam int SEQ_LSB = 24;
    localparam int VAL_LSB = 0;
    localparam int VAL_W   = 24;

    // Longest wait for a sensor to acknowledge a request
    localparam logic [23:0] HI_TMO_CYC = 24'd16;

    function automatic logic [31:0] make_word(input logic [1:0]       tag,
                                              input logic [1:0]       ch,
                                              input logic [3:0]       seq,
                                              input logic [VAL_W-1:0] val);
        logic [31:0] w;
        w = '0;
        w[TAG_LSB +: 2]     = tag;
        w[CH_LSB  +: 2]     = ch;
        w[SEQ_LSB +: 4]     = seq;
        w[VAL_LSB +: VAL_W] = val;
        return w;
    endfunction

endpackage

// File: rtl/sensor_rr_pick.sv
// Round-robin channel picker: returns the first enabled channel strictly
// after i_last, wrapping NUM_CH-1 -> 0; o_valid is low for an empty mask.
module sensor_rr_pick #(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0] i_mask,
    input  logic [1:0]        i_last,
    output logic [1:0]        o_next,
    output logic              o_valid
);

    logic [1:0] w_idx;

    // Scan from the farthest offset down to the nearest so the nearest hit wins
    always_comb begin
        // NOTE: every combinational output gets a default first; any path that
        // leaves one unassigned would otherwise infer a latch.
        o_next  = i_last;
        o_valid = 1'b0;
        w_idx   = '0;
        for (int off = NUM_CH; off >= 1; off--) begin
            w_idx = 2'((int'(i_last) + off) % NUM_CH);
            if (i_mask[w_idx]) begin
                o_next  = w_idx;
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sensor_sched.sv
// Sensor scheduler: takes commands from an input FIFO, runs periodic
// round-robin or one-shot measurements over up to four sonic_sensor
// channels, and writes tagged result words to an output FIFO.
// Optional build macro SENSOR_SCHED_TIMEOUT_EN adds busy-handshake timeouts
// that emit a tag 2'b11 error word instead of waiting forever.
module sensor_sched
    import sensor_sched_pkg::*;
#(
    parameter int          NUM_CH  = 4,
    parameter logic [23:0] TMO_CYC = 24'd2_000_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          cmd_data,
    input  logic                 cmd_empty,
    output logic                 cmd_rden,
    output logic [31:0]          snd_data,
    output logic                 snd_en,
    input  logic                 snd_full,
    output logic [NUM_CH-1:0]    sens_req,
    input  logic [NUM_CH-1:0]    sens_busy,
    input  logic [NUM_CH*32-1:0] sens_data,
    output logic [1:0]           cur_ch
);

    state_t              r_state;
    state_t              w_next;
    logic [NUM_CH-1:0]   r_mask;
    logic [23:0]         r_period;
    logic [23:0]         r_per_cnt;
    logic [1:0]          r_rr_ptr;
    logic [1:0]          r_cur_ch;
    logic [1:0]          r_os_ch;
    logic                r_oneshot;
    logic [3:0]          r_seq;
    logic [31:0]         r_snd_word;

    logic                w_cmd_rden;
    logic                w_snd_en;
    logic [NUM_CH-1:0]   w_req;
    logic                w_tmo;
    logic                w_tick;
    logic                w_busy;
    logic [VAL_W-1:0]    w_val;
    logic [1:0]          w_pick_last;
    logic [1:0]          w_pick_next;
    logic                w_pick_valid;
    logic [1:0]          w_start_ch;
    logic                w_load_word;
    logic [1:0]          w_tag;
    logic                w_unused;

`ifdef SENSOR_SCHED_TIMEOUT_EN
    logic [23:0]         r_tmo_cnt;
`endif

    assign w_tick = (r_per_cnt >= r_period);
    assign w_busy = sens_busy[r_cur_ch];
    assign w_val  = sens_data[{r_cur_ch, 5'd0} +: VAL_W];

    // In NEXT advance past the channel just served; in IDLE resolve the
    // stored pointer against the current mask (it may have been disabled).
    assign w_pick_last = (r_state == NEXT) ? r_cur_ch : r_rr_ptr;
    assign w_start_ch  = r_mask[r_rr_ptr] ? r_rr_ptr : w_pick_next;

    sensor_rr_pick #(
        .NUM_CH (NUM_CH)
    ) u_rr_pick (
        .i_mask  (r_mask),
        .i_last  (w_pick_last),
        .o_next  (w_pick_next),
        .o_valid (w_pick_valid)
    );

    // Next-state and handshake outputs
    always_comb begin
        w_next     = r_state;
        w_cmd_rden = 1'b0;
        w_snd_en   = 1'b0;
        w_req      = '0;
        w_tmo      = 1'b0;
        case (r_state)
            IDLE: begin
                if (!cmd_empty)              w_next = CMD_RD;
                else if (r_oneshot)          w_next = REQ;
                else if (|r_mask && w_tick)  w_next = REQ;
            end
            CMD_RD: begin
                w_cmd_rden = 1'b1;
                w_next     = CMD_DEC;
            end
            CMD_DEC: w_next = IDLE;
            REQ: begin
                w_req[r_cur_ch] = 1'b1;
                w_next          = WAIT_HI;
            end
            WAIT_HI: begin
                if (w_busy) w_next = WAIT_LO;
`ifdef SENSOR_SCHED_TIMEOUT_EN
                else if (r_tmo_cnt == HI_TMO_CYC) begin
                    w_next = SND;
                    w_tmo  = 1'b1;
                end
`endif
            end
            WAIT_LO: begin
                if (!w_busy) w_next = SND;
`ifdef SENSOR_SCHED_TIMEOUT_EN
                else if (r_tmo_cnt == TMO_CYC) begin
                    w_next = SND;
                    w_tmo  = 1'b1;
                end
`endif
            end
            SND: begin
                if (!snd_full) begin
                    w_snd_en = 1'b1;
                    w_next   = NEXT;
                end
            end
            NEXT:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    assign w_load_word = (w_next == SND) && (r_state != SND);
    assign w_tag       = w_tmo ? TAG_TMO : (r_oneshot ? TAG_ONESHOT : TAG_MEAS);

    // Configuration, channel selection, result capture and sequence number
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask     <= '0;
            r_period   <= '0;
            r_per_cnt  <= '0;
            r_rr_ptr   <= '0;
            r_cur_ch   <= '0;
            r_os_ch    <= '0;
            r_oneshot  <= 1'b0;
            r_seq      <= '0;
            r_snd_word <= '0;
        end else begin
            if (r_state == NEXT)          r_per_cnt <= '0;
            else if (r_per_cnt != '1)     r_per_cnt <= r_per_cnt + 24'd1;

            if (r_state == CMD_DEC) begin
                case (cmd_data[31:28])
                    OP_MASK:   r_mask   <= cmd_data[NUM_CH-1:0];
                    OP_PERIOD: r_period <= cmd_data[23:0];
                    OP_ONESHOT: begin
                        if (int'(cmd_data[1:0]) < NUM_CH) begin
                            r_oneshot <= 1'b1;
                            r_os_ch   <= cmd_data[1:0];
                        end
                    end
                    default: ;
                endcase
            end

            if (r_state == IDLE && w_next == REQ)
                r_cur_ch <= r_oneshot ? r_os_ch : w_start_ch;

            if (w_load_word)
                r_snd_word <= make_word(w_tag, r_cur_ch, r_seq, w_tmo ? '0 : w_val);

            if (w_snd_en) r_seq <= r_seq + 4'd1;

            // One-shots leave the round-robin pointer where it was
            if (r_state == NEXT) begin
                r_oneshot <= 1'b0;
                if (!r_oneshot && w_pick_valid) r_rr_ptr <= w_pick_next;
            end
        end
    end

`ifdef SENSOR_SCHED_TIMEOUT_EN
    // Cycles spent in the current state; restarts on every transition
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 r_tmo_cnt <= '0;
        else if (w_next != r_state) r_tmo_cnt <= '0;
        else                        r_tmo_cnt <= r_tmo_cnt + 24'd1;
    end
`endif

    // Input bits that carry no meaning for this block
    always_comb begin
        w_unused = ^cmd_data[27:24];
        for (int c = 0; c < NUM_CH; c++)
            w_unused = w_unused ^ (^sens_data[c*32+24 +: 8]);
`ifndef SENSOR_SCHED_TIMEOUT_EN
        w_unused = w_unused ^ (^TMO_CYC);
`endif
    end

    assign cmd_rden = w_cmd_rden;
    assign snd_en   = w_snd_en;
    assign snd_data = r_snd_word;
    assign sens_req = w_req;
    assign cur_ch   = r_cur_ch;

endmodule

// File: tb/tb_sensor_sched.sv
// Directed testbench for sensor_sched: behavioural command FIFO, output
// monitor and sensor models; expected words built from the documented
// {tag, ch, seq, value} layout. Timeout scenario runs only when the bench
// is built with SENSOR_SCHED_TIMEOUT_EN.
module tb_sensor_sched;

    localparam int NUM_CH = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [31:0]          cmd_data;
    logic                 cmd_empty = 1'b1;
    logic                 cmd_rden;
    logic [31:0]          snd_data;
    logic                 snd_en;
    logic                 snd_full;
    logic [NUM_CH-1:0]    sens_req;
    logic [NUM_CH-1:0]    sens_busy;
    logic [NUM_CH*32-1:0] sens_data;
    logic [1:0]           cur_ch;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          n_rden   = 0;
    int          n_req    = 0;
    int          req1_cyc = -1;
    int          exp_seq  = 0;
    int          last_cyc = -1;
    logic [31:0] cmd_q[$];
    logic [31:0] mon_q[$];
    int          mon_cyc[$];
    bit          dead[NUM_CH];
    int          busy_cnt[NUM_CH];

    // Channel results; upper bytes hold junk that must not reach the word
    assign sens_data = {32'h0000_0777, 32'hFF00_1234, 32'hAB00_0064, 32'h0000_0064};

    always #5 clk = ~clk;

    sensor_sched #(
        .NUM_CH  (NUM_CH),
        .TMO_CYC (24'd2_000_000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_data  (cmd_data),
        .cmd_empty (cmd_empty),
        .cmd_rden  (cmd_rden),
        .snd_data  (snd_data),
        .snd_en    (snd_en),
        .snd_full  (snd_full),
        .sens_req  (sens_req),
        .sens_busy (sens_busy),
        .sens_data (sens_data),
        .cur_ch    (cur_ch)
    );

    // Sensor model: busy rises the edge after a request and stays high 5 cycles
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sens_busy <= '0;
            for (int c = 0; c < NUM_CH; c++) busy_cnt[c] <= 0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (sens_req[c] && !dead[c]) begin
                    sens_busy[c] <= 1'b1;
                    busy_cnt[c]  <= 5;
                end else if (busy_cnt[c] == 1) begin
                    sens_busy[c] <= 1'b0;
                    busy_cnt[c]  <= 0;
                end else if (busy_cnt[c] > 1) begin
                    busy_cnt[c] <= busy_cnt[c] - 1;
                end
            end
        end
    end

    // Cycle count and command FIFO read port (data the cycle after rden)
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cmd_rden && cmd_q.size() > 0) cmd_data <= cmd_q.pop_front();
    end

    // Mid-cycle monitor: FIFO flag, read pulses, requests, output writes
    always @(negedge clk) begin
        cmd_empty = (cmd_q.size() == 0);
        if (cmd_rden) n_rden++;
        if (|sens_req) n_req++;
        if (sens_req[1]) req1_cyc = cyc;
        if (snd_en) begin
            mon_q.push_back(snd_data);
            mon_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [31:0] w);
        cmd_q.push_back(w);
    endtask

    task automatic wait_words(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (mon_q.size() < n && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        check(tag, 32'(mon_q.size() >= n), 32'd1);
    endtask

    task automatic expect_word(input string tag, input logic [1:0] tg,
                               input logic [1:0] ch, input logic [23:0] val);
        logic [31:0] got;
        got      = 'x;
        last_cyc = -1;
        if (mon_q.size() > 0) begin
            got      = mon_q.pop_front();
            last_cyc = mon_cyc.pop_front();
        end
        check(tag, got, {tg, ch, exp_seq[3:0], val});
        exp_seq = (exp_seq + 1) % 16;
    endtask

    initial begin
        int          c0;
        int          req_before;
        logic [1:0]  ch_exp;
        logic [31:0] held;
        bit          stable;
        int          k;

        rst_n    = 1'b0;
        snd_full = 1'b0;
        cmd_data = '0;
        for (int c = 0; c < NUM_CH; c++) dead[c] = 1'b0;

        // Reset values
        step(3);
        @(negedge clk); #1;
        check("rst_sens_req", 32'(sens_req), 32'd0);
        check("rst_cmd_rden", 32'(cmd_rden), 32'd0);
        check("rst_snd_en",   32'(snd_en),   32'd0);
        check("rst_snd_data", snd_data,      32'd0);
        check("rst_cur_ch",   32'(cur_ch),   32'd0);
        step(1);
        rst_n = 1'b1;

        // Empty mask: nothing happens on its own
        step(20);
        check("idle_no_req",  n_req,        0);
        check("idle_no_word", mon_q.size(), 0);

        // Unknown opcodes: consumed, no side effects
        push_cmd(32'hF000_0000);
        push_cmd(32'h0000_000F);
        step(20);
        check("badop_rden",    n_rden,       2);
        check("badop_no_req",  n_req,        0);
        check("badop_no_word", mon_q.size(), 0);

        // One-shot on ch2 with mask 0: exactly one tagged word
        push_cmd(32'h3000_0002);
        wait_words(1, 60, "oneshot_arrive");
        expect_word("oneshot_word", 2'b10, 2'd2, 24'h001234);
        step(30);
        check("oneshot_single", mon_q.size(), 0);
        check("oneshot_req",    n_req,        1);
        check("oneshot_cur_ch", 32'(cur_ch),  32'd2);

        // Mask ch0|ch1, period 0: back-to-back round-robin
        push_cmd(32'h1000_0003);
        push_cmd(32'h2000_0000);
        wait_words(3, 120, "rr_arrive");
        expect_word("rr_w0", 2'b01, 2'd0, 24'h64);
        c0 = last_cyc;
        expect_word("rr_w1", 2'b01, 2'd1, 24'h64);
        check("rr_b2b_gap", last_cyc - c0, 10);
        expect_word("rr_w2", 2'b01, 2'd0, 24'h64);
        push_cmd(32'h1000_0000);
        step(60);
        ch_exp = 2'd1;
        while (mon_q.size() > 0) begin
            expect_word("rr_tail", 2'b01, ch_exp, 24'h64);
            ch_exp = (ch_exp == 2'd0) ? 2'd1 : 2'd0;
        end
        step(30);
        check("rr_stopped", mon_q.size(), 0);

        // Output FIFO full: word held stable, written once on release
        snd_full = 1'b1;
        push_cmd(32'h2000_0032);
        push_cmd(32'h1000_0001);
        step(20);
        held   = snd_data;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (snd_data !== held || snd_en !== 1'b0) stable = 1'b0;
        end
        #1;
        check("stall_no_write", mon_q.size(), 0);
        check("stall_stable",   32'(stable),  32'd1);
        check("stall_word",     held,         {2'b01, 2'd0, exp_seq[3:0], 24'h64});
        step(1);
        snd_full = 1'b0;
        wait_words(1, 5, "stall_release");
        expect_word("stall_out", 2'b01, 2'd0, 24'h64);
        c0 = last_cyc;
        step(3);
        check("stall_single", mon_q.size(), 0);

        // Period 50: next measurement 50 idle cycles later
        wait_words(1, 100, "period_arrive");
        expect_word("period_word", 2'b01, 2'd0, 24'h64);
        check("period_gap", last_cyc - c0, 60);
        push_cmd(32'h1000_0000);
        step(80);
        check("period_stopped", mon_q.size(), 0);

        // Reset while ch1 is in its busy-low wait
        push_cmd(32'h1000_0002);
        k = 0;
        while (sens_busy[1] !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("pre_rst_busy", 32'(sens_busy[1]), 32'd1);
        step(2);
        check("pre_rst_cur_ch", 32'(cur_ch), 32'd1);
        #2;
        rst_n   = 1'b0;
        exp_seq = 0;
        #1;
        check("rst_mid_req",    32'(sens_req), 32'd0);
        check("rst_mid_cur_ch", 32'(cur_ch),   32'd0);
        check("rst_mid_data",   snd_data,      32'd0);
        step(2);
        rst_n      = 1'b1;
        req_before = n_req;
        step(30);
        check("rst_no_word", mon_q.size(), 0);
        check("rst_no_req",  n_req,        req_before);

        // After reset: seq restarts at 0, one-shot on ch1
        push_cmd(32'h3000_0001);
        wait_words(1, 60, "post_rst_arrive");
        expect_word("post_rst_oneshot", 2'b10, 2'd1, 24'h64);

        // Mask ch1|ch3 with pointer at 0: starts at ch1, wraps 3 -> 1
        push_cmd(32'h1000_000A);
        wait_words(3, 120, "rr13_arrive");
        expect_word("rr13_w0", 2'b01, 2'd1, 24'h64);
        expect_word("rr13_w1", 2'b01, 2'd3, 24'h777);
        expect_word("rr13_w2", 2'b01, 2'd1, 24'h64);
        push_cmd(32'h1000_0000);
        step(60);
        ch_exp = 2'd3;
        while (mon_q.size() > 0) begin
            expect_word("rr13_tail", 2'b01, ch_exp, (ch_exp == 2'd3) ? 24'h777 : 24'h64);
            ch_exp = (ch_exp == 2'd3) ? 2'd1 : 2'd3;
        end

`ifdef SENSOR_SCHED_TIMEOUT_EN
        // Ch1 never acknowledges: error word after 17 cycles, then carry on
        dead[1] = 1'b1;
        push_cmd(32'h3000_0001);
        wait_words(1, 60, "tmo_arrive");
        expect_word("tmo_word", 2'b11, 2'd1, 24'h0);
        check("tmo_latency", last_cyc - req1_cyc, 18);
        dead[1] = 1'b0;
        push_cmd(32'h3000_0000);
        wait_words(1, 60, "tmo_continue_arrive");
        expect_word("tmo_continue", 2'b10, 2'd0, 24'h64);
`endif

        step(5);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
